// File: rtl/alu_cmd_sequencer.sv
// Command-level sequencer for the 16-bit ALU breadboard: accepts commands, drives the ALU,
// waits a fixed latency, writes the result into a 32-bit accumulator and returns a response.
module alu_cmd_sequencer #(
    parameter int unsigned ALU_LAT  = 1,
    parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_operand,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_error,
    output logic [31:0] acc,
    output logic [1:0]  err_sticky,
    input  logic        clr_err
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned ERR_W  = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL   = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV   = 4'b0011;
    localparam logic [OP_W-1:0] OP_MOD   = 4'b0100;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'b1000;
    localparam logic [OP_W-1:0] OP_CLEAR = 4'b1001;
    localparam logic [OP_W-1:0] OP_READ  = 4'b1010;

    localparam logic [ERR_W-1:0] ERR_NONE   = 2'b00;
    localparam logic [ERR_W-1:0] ERR_DIV0   = 2'b10;
    localparam logic [ERR_W-1:0] ERR_UNSUPP = 2'b11;
    localparam logic [ERR_W-1:0] MASK_OVF   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [OP_W-1:0]    alu_op_q, alu_op_d;
    logic [ACC_W-1:0]   rsp_result_q, rsp_result_d;
    logic [ERR_W-1:0]   rsp_error_q, rsp_error_d;
    logic [ERR_W-1:0]   err_sticky_q, err_sticky_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               cmd_ready_q, cmd_ready_d;

    logic               enter_resp;
    logic [ERR_W-1:0]   new_err;
    logic               is_divmod;
    logic [ERR_W-1:0]   err_mask;

    // Error mask for the operation currently held on the ALU.
    always_comb begin
        is_divmod = (alu_op_q == OP_DIV) || (alu_op_q == OP_MOD);
        err_mask  = ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) ? MASK_OVF : ERR_NONE;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        enter_resp   = 1'b0;
        new_err      = ERR_NONE;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_op <= OP_MOD) begin
                        alu_a_d  = acc_q[DATA_W-1:0];
                        alu_b_d  = cmd_operand;
                        alu_op_d = cmd_op;
                        cnt_d    = CNT_W'(ALU_LAT - 1);
                        state_d  = S_EXEC;
                    end else begin
                        enter_resp = 1'b1;
                        unique case (cmd_op)
                            OP_LOAD:  acc_d = {{(ACC_W-DATA_W){1'b0}}, cmd_operand};
                            OP_CLEAR: acc_d = '0;
                            OP_READ:  acc_d = acc_q;
                            default:  new_err = ERR_UNSUPP;
                        endcase
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    enter_resp = 1'b1;
                    if (is_divmod && alu_error[1]) begin
                        new_err = ERR_DIV0;
                    end else begin
                        acc_d   = alu_result;
                        new_err = alu_error & err_mask;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            state_d      = S_RESP;
            rsp_result_d = acc_d;
            rsp_error_d  = new_err;
        end

        // A clear and a fresh error on the same edge leave the fresh bits set.
        err_sticky_d = (clr_err ? ERR_NONE : err_sticky_q) | new_err;
        rsp_valid_d  = (state_d == S_RESP);
        cmd_ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= ACC_INIT;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_ADD;
            rsp_result_q <= '0;
            rsp_error_q  <= ERR_NONE;
            err_sticky_q <= ERR_NONE;
            rsp_valid_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            err_sticky_q <= err_sticky_d;
            rsp_valid_q  <= rsp_valid_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign acc        = acc_q;
    assign err_sticky = err_sticky_q;

endmodule
